// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default latencies.
// MDU_MADD_EN enables the MADD/MADDU accumulate ops.
package md_defs;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MADDU = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for several cycles and commit through the counter.
  function automatic logic is_multi_cycle(md_op_e op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU:                  return 1'b1;
`endif
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_mul_class(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface md_unit_if
  import md_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, md_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/md_unit_calc.sv
// Combinational result generator: 2*WIDTH {hi,lo} value for a latched op and operands.
// o_wr_en is low when HI/LO must stay unchanged (divide by zero, non-arithmetic ops).
module md_calc
  import md_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  md_op_e             i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
`ifdef MDU_MADD_EN
  input  logic [2*WIDTH-1:0] i_acc,
`endif
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_wr_en
);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [WIDTH-1:0]   w_divisor_s;
  logic [WIDTH-1:0]   w_divisor_u;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_quot_u;
  logic [WIDTH-1:0]   w_rem_u;

  assign w_prod_s = $unsigned($signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) *
                              $signed({{WIDTH{i_b[WIDTH-1]}}, i_b}));
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  assign w_div_zero = (i_b == '0);
  assign w_div_ovf  = (i_a == MIN_INT) && (i_b == '1);

  // Dividing by 1 instead yields exactly min_int rem 0 for the overflow case and keeps
  // the divider away from a zero divisor; the zero case is discarded via o_wr_en.
  assign w_divisor_s = (w_div_zero || w_div_ovf) ? WIDTH'(1) : i_b;
  assign w_divisor_u = w_div_zero ? WIDTH'(1) : i_b;

  assign w_quot_s = $unsigned($signed(i_a) / $signed(w_divisor_s));
  assign w_rem_s  = $unsigned($signed(i_a) % $signed(w_divisor_s));
  assign w_quot_u = i_a / w_divisor_u;
  assign w_rem_u  = i_a % w_divisor_u;

  // NOTE: every output gets a default before the case, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    o_result = '0;
    o_wr_en  = 1'b0;
    case (i_op)
      MD_MULT:  begin o_result = w_prod_s;           o_wr_en = 1'b1;        end
      MD_MULTU: begin o_result = w_prod_u;           o_wr_en = 1'b1;        end
      MD_DIV:   begin o_result = {w_rem_s, w_quot_s}; o_wr_en = !w_div_zero; end
      MD_DIVU:  begin o_result = {w_rem_u, w_quot_u}; o_wr_en = !w_div_zero; end
`ifdef MDU_MADD_EN
      MD_MADD:  begin o_result = i_acc + w_prod_s;   o_wr_en = 1'b1;        end
      MD_MADDU: begin o_result = i_acc + w_prod_u;   o_wr_en = 1'b1;        end
`endif
      default:  ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers: IDLE/RUN FSM, latency counter,
// operand latches and HI/LO. Define MDU_MADD_EN to add MADD/MADDU accumulation.
module md_unit
  import md_defs::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic   clk,
  input logic   reset,
  md_unit_if.slave md
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] r_acc;
`endif

  md_op_e             w_op;
  logic               w_idle_start;
  logic               w_launch;
  logic               w_commit;
  logic [2*WIDTH-1:0] w_result;
  logic               w_wr_en;

  assign w_op         = md_op_e'(md.md_op);
  assign w_idle_start = (r_state == ST_IDLE) && md.start;
  assign w_launch     = w_idle_start && is_multi_cycle(w_op);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = is_mul_class(w_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: the operand latches are reset too, so the pending result is well defined
  // after reset and an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op  <= MD_MULT;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
`ifdef MDU_MADD_EN
      r_acc <= '0;
`endif
    end else begin
      if (w_launch) begin
        r_op  <= w_op;
        r_a   <= md.src_a;
        r_b   <= md.src_b;
`ifdef MDU_MADD_EN
        r_acc <= {r_hi, r_lo};
`endif
      end
      // Commit only happens in RUN and MTHI/MTLO only in IDLE, so these never collide.
      if (w_commit && w_wr_en) begin
        {r_hi, r_lo} <= w_result;
      end else if (w_idle_start && (w_op == MD_MTHI)) begin
        r_hi <= md.src_a;
      end else if (w_idle_start && (w_op == MD_MTLO)) begin
        r_lo <= md.src_a;
      end
    end
  end

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
`ifdef MDU_MADD_EN
    .i_acc    (r_acc),
`endif
    .o_result (w_result),
    .o_wr_en  (w_wr_en)
  );

  assign md.busy = (r_state == ST_RUN);
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO/busy-length per operation,
// a monitor pops and compares each time busy falls.
module tb_md_unit;
  import md_defs::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_commit(input string name, input logic [31:0] hi, input logic [31:0] lo,
                               input int cycles);
    exp_t e;
    e.name   = name;
    e.hi     = hi;
    e.lo     = lo;
    e.cycles = cycles;
    sb_q.push_back(e);
  endtask

  // One-cycle start pulse; operands are scrambled right after the launch edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.src_a = ~a;
    bus.src_b = b + 32'h55;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(n < 100), 64'(1));
    @(negedge clk);
  endtask

  // Monitor: counts busy cycles, compares against the scoreboard when busy falls.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt = 0;
      end else if (bus.busy) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_commit: got hi=%h lo=%h, expected no commit", bus.hi, bus.lo);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
          check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.cycles));
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    #12;
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    reset = 1'b1;

    // -1 * 2 = -2 signed; 0xFFFFFFFF * 2 = 0x1_FFFFFFFE unsigned.
    expect_commit("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_idle("mult");
    expect_commit("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu");

    // -7 / 2 = -3 rem -1; 7 / 2 = 3 rem 1.
    expect_commit("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");
    expect_commit("divu", 32'd1, 32'd3, 10);
    issue(3'd3, 32'd7, 32'd2);
    wait_idle("divu");

    // MTHI/MTLO write on the start edge, no busy.
    issue(3'd4, 32'h1234, 32'd0);
    check("mthi_hi", 64'(bus.hi), 64'h1234);
    check("mthi_busy", 64'(bus.busy), 64'(0));
    issue(3'd5, 32'h5678, 32'd0);
    check("mtlo_lo", 64'(bus.lo), 64'h5678);
    check("mtlo_hi_kept", 64'(bus.hi), 64'h1234);

    expect_commit("div_by_zero", 32'h1234, 32'h5678, 10);
    issue(3'd2, 32'd99, 32'd0);
    wait_idle("div_by_zero");

    expect_commit("div_ovf", 32'h0, 32'h8000_0000, 10);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    // MTLO during busy cycle 2 must be ignored.
    expect_commit("start_while_busy", 32'h0, 32'd12, 5);
    issue(3'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.md_op = 3'd5;
    bus.src_a = 32'hAA;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle("start_while_busy");

`ifdef MDU_MADD_EN
    issue(3'd4, 32'h0, 32'h0);
    issue(3'd5, 32'h1, 32'h0);
    expect_commit("madd", 32'h0, 32'd2, 5);
    issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("madd");
`else
    issue(3'd6, 32'd5, 32'd7);
    check("op6_noop_busy", 64'(bus.busy), 64'(0));
    check("op6_noop_hi", 64'(bus.hi), 64'h0);
    check("op6_noop_lo", 64'(bus.lo), 64'd12);
    issue(3'd7, 32'd5, 32'd7);
    check("op7_noop_busy", 64'(bus.busy), 64'(0));
`endif

    // Reset in busy cycle 3 of a DIVU: abort, clear, never commit.
    issue(3'd3, 32'd100, 32'd3);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'(0));
    check("rst_mid_hi", 64'(bus.hi), 64'(0));
    check("rst_mid_lo", 64'(bus.lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(bus.busy), 64'(0));
    check("post_rst_hi", 64'(bus.hi), 64'(0));
    check("post_rst_lo", 64'(bus.lo), 64'(0));

    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
